// File: rtl/alu_seq_ctrl.sv
// Multi-cycle sequencer for a combinational N-bit ALU: single-pass ops take one
// ALU pass, shifts repeat the ALU's 1-bit shift shamt times through work register w.
module alu_seq_ctrl #(
    parameter int N   = 32,
    parameter int SHW = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [3:0]     op,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    input  logic [SHW-1:0] shamt,
    output logic [N-1:0]   alu_a,
    output logic [N-1:0]   alu_b,
    output logic [3:0]     alu_ctrl,
    input  logic [N-1:0]   alu_result,
    input  logic [3:0]     alu_flags,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic [N-1:0]   result,
    output logic [3:0]     flags
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t         state, state_next;
    logic [3:0]     op_q, op_next;
    logic [N-1:0]   w_q, w_next;
    logic [N-1:0]   b_q, b_next;
    logic [SHW-1:0] cnt_q, cnt_next;
    logic [N-1:0]   result_q, result_next;
    logic [3:0]     flags_q, flags_next;
    logic           err_q, err_next;

    logic op_shift;
    logic op_illegal;

    assign op_shift   = (op >= 4'd6) && (op <= 4'd9);
    assign op_illegal = (op > 4'd9);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values computed by the combinational block.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            op_q     <= '0;
            w_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_next;
            op_q     <= op_next;
            w_q      <= w_next;
            b_q      <= b_next;
            cnt_q    <= cnt_next;
            result_q <= result_next;
            flags_q  <= flags_next;
            err_q    <= err_next;
        end
    end

    // NOTE: every signal written here gets a default first; a missing default on
    // any path would infer a latch.
    always_comb begin
        state_next  = state;
        op_next     = op_q;
        w_next      = w_q;
        b_next      = b_q;
        cnt_next    = cnt_q;
        result_next = result_q;
        flags_next  = flags_q;
        err_next    = err_q;
        alu_a       = '0;
        alu_b       = '0;
        alu_ctrl    = '0;

        case (state)
            IDLE: begin
                if (start) begin
                    op_next = op;
                    w_next  = a;
                    b_next  = b;
                    if (op_illegal) begin
                        result_next = '0;
                        flags_next  = '0;
                        err_next    = 1'b1;
                        state_next  = DONE;
                    end else if (op_shift && (shamt == '0)) begin
                        // Zero-distance shift bypasses the ALU entirely.
                        result_next = a;
                        flags_next  = '0;
                        err_next    = 1'b0;
                        state_next  = DONE;
                    end else begin
                        cnt_next   = op_shift ? shamt : SHW'(1);
                        state_next = EXEC;
                    end
                end
            end
            EXEC: begin
                alu_a    = w_q;
                alu_b    = b_q;
                alu_ctrl = op_q;
                w_next   = alu_result;
                cnt_next = cnt_q - 1'b1;
                if (cnt_q == SHW'(1)) begin
                    result_next = alu_result;
                    flags_next  = alu_flags;
                    err_next    = 1'b0;
                    state_next  = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy   = (state == EXEC);
    assign done   = (state == DONE);
    assign err    = err_q;
    assign result = result_q;
    assign flags  = flags_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl: a behavioural 1-bit-shift ALU sits beside the
// sequencer, and whole-operation expectations are queued at start and popped at done.
module tb_alu_seq_ctrl;

    localparam int N   = 32;
    localparam int SHW = 5;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [3:0]     op;
    logic [N-1:0]   a, b;
    logic [SHW-1:0] shamt;
    logic [N-1:0]   alu_a, alu_b, alu_result;
    logic [3:0]     alu_ctrl, alu_flags;
    logic           busy, done, err;
    logic [N-1:0]   result;
    logic [3:0]     flags;

    alu_seq_ctrl #(.N(N), .SHW(SHW)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .shamt(shamt),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .busy(busy), .done(done), .err(err), .result(result), .flags(flags)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: flags {Z,N,C,V}; shifts move one bit, C = bit shifted out.
    logic alu_c, alu_v;
    always_comb begin
        alu_result = '0;
        alu_c      = 1'b0;
        alu_v      = 1'b0;
        case (alu_ctrl)
            4'd0: begin
                {alu_c, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
                alu_v = (alu_a[N-1] == alu_b[N-1]) && (alu_result[N-1] != alu_a[N-1]);
            end
            4'd1: begin
                alu_result = alu_a - alu_b;
                alu_c      = (alu_a >= alu_b);
                alu_v      = (alu_a[N-1] != alu_b[N-1]) && (alu_result[N-1] != alu_a[N-1]);
            end
            4'd2: alu_result = alu_a & alu_b;
            4'd3: alu_result = alu_a | alu_b;
            4'd4: alu_result = alu_a ^ alu_b;
            4'd5: alu_result = ~alu_a;
            4'd6, 4'd8: begin
                alu_result = alu_a << 1;
                alu_c      = alu_a[N-1];
            end
            4'd7: begin
                alu_result = {alu_a[N-1], alu_a[N-1:1]};
                alu_c      = alu_a[0];
            end
            4'd9: begin
                alu_result = alu_a >> 1;
                alu_c      = alu_a[0];
            end
            default: alu_result = '0;
        endcase
        alu_flags = {(alu_result == '0), alu_result[N-1], alu_c, alu_v};
    end

    typedef struct {
        logic [N-1:0] res;
        logic [3:0]   flg;
        logic         err;
        int           due_cyc;
    } exp_t;

    exp_t         sb[$];
    int           cyc = 0;
    int           n_vec = 0;
    int           n_miss = 0;
    logic [N-1:0] held_res = '0;
    logic [3:0]   held_flg = '0;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference for a whole operation, computed directly rather than pass by pass.
    function automatic void model(input logic [3:0] m_op, input logic [N-1:0] m_a,
                                  input logic [N-1:0] m_b, input logic [SHW-1:0] m_sh,
                                  output exp_t e, output int lat);
        logic [N-1:0] r;
        logic         c, v;
        int           k;
        r = '0; c = 1'b0; v = 1'b0; k = int'(m_sh);
        e.err = 1'b0;
        lat   = 2;
        if (m_op > 4'd9) begin
            e.res = '0; e.flg = '0; e.err = 1'b1; lat = 1;
        end else if (m_op >= 4'd6 && k == 0) begin
            e.res = m_a; e.flg = '0; lat = 1;
        end else begin
            case (m_op)
                4'd0: begin
                    {c, r} = {1'b0, m_a} + {1'b0, m_b};
                    v = (m_a[N-1] == m_b[N-1]) && (r[N-1] != m_a[N-1]);
                end
                4'd1: begin
                    r = m_a - m_b; c = (m_a >= m_b);
                    v = (m_a[N-1] != m_b[N-1]) && (r[N-1] != m_a[N-1]);
                end
                4'd2: r = m_a & m_b;
                4'd3: r = m_a | m_b;
                4'd4: r = m_a ^ m_b;
                4'd5: r = ~m_a;
                4'd6, 4'd8: begin r = m_a << k; c = m_a[N-k]; lat = k + 1; end
                4'd7: begin r = N'($signed(m_a) >>> k); c = m_a[k-1]; lat = k + 1; end
                default: begin r = m_a >> k; c = m_a[k-1]; lat = k + 1; end
            endcase
            e.res = r;
            e.flg = {(r == '0), r[N-1], c, v};
        end
    endfunction

    // Monitor: pop at each done, otherwise the registered outputs must hold.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (done) begin
                if (sb.size() == 0) begin
                    check("spurious_done", 64'(done), 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("result", 64'(result), 64'(e.res));
                    check("flags", 64'(flags), 64'(e.flg));
                    check("err", 64'(err), 64'(e.err));
                    check("done_cycle", 64'(cyc), 64'(e.due_cyc));
                    held_res = e.res;
                    held_flg = e.flg;
                end
            end else begin
                check("result_hold", 64'(result), 64'(held_res));
                check("flags_hold", 64'(flags), 64'(held_flg));
            end
        end
    end

    function automatic void expect_op(input logic [3:0] m_op, input logic [N-1:0] m_a,
                                      input logic [N-1:0] m_b, input logic [SHW-1:0] m_sh,
                                      input int start_edge);
        exp_t e;
        int   lat;
        model(m_op, m_a, m_b, m_sh, e, lat);
        e.due_cyc = start_edge + lat - 1;
        sb.push_back(e);
    endfunction

    // Pulse start for one edge; returns at the negedge after the start edge.
    task automatic send(input logic [3:0] s_op, input logic [N-1:0] s_a,
                        input logic [N-1:0] s_b, input logic [SHW-1:0] s_sh);
        @(negedge clk);
        start = 1'b1; op = s_op; a = s_a; b = s_b; shamt = s_sh;
        expect_op(s_op, s_a, s_b, s_sh, cyc + 1);
        @(negedge clk);
        start = 1'b0;
        op = 4'($urandom); a = $urandom; b = $urandom; shamt = SHW'($urandom);
    endtask

    task automatic wait_done();
        #1;
        for (int i = 0; i < 200 && sb.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            check("done_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; shamt = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_flags", 64'(flags), 64'd0);
        check("rst_alu_a", 64'(alu_a), 64'd0);
        check("rst_alu_ctrl", 64'(alu_ctrl), 64'd0);
        rst = 1'b0;

        // Add and sub
        send(4'd0, 32'd5, 32'd7, 5'd0);
        wait_done();
        send(4'd1, 32'd5, 32'd5, 5'd0);
        wait_done();

        // rsl by 4: alu_a walks the value down one bit per EXEC cycle
        send(4'd9, 32'h8000_0000, 32'd0, 5'd4);
        for (int k = 0; k < 4; k++) begin
            check("rsl_alu_a", 64'(alu_a), 64'(32'h8000_0000 >> k));
            check("rsl_alu_ctrl", 64'(alu_ctrl), 64'd9);
            check("rsl_busy", 64'(busy), 64'd1);
            if (k < 3) @(negedge clk);
        end
        wait_done();

        // rsa by the maximum distance
        send(4'd7, 32'h8000_0000, 32'd0, 5'd31);
        wait_done();

        // Zero-distance shift and illegal op bypass the ALU
        send(4'd8, 32'h1234, 32'd0, 5'd0);
        check("sh0_alu_ctrl", 64'(alu_ctrl), 64'd0);
        wait_done();
        send(4'd12, 32'hdead_beef, 32'h1, 5'd3);
        wait_done();
        send(4'd15, 32'h1, 32'h1, 5'd0);
        wait_done();

        // Random single-pass ops and shifts, incl. overflow corners
        send(4'd0, 32'h7fff_ffff, 32'd1, 5'd0);
        wait_done();
        send(4'd1, 32'h8000_0000, 32'd1, 5'd0);
        wait_done();
        for (int i = 0; i < 12; i++) begin
            send(4'($urandom_range(0, 5)), $urandom, $urandom, 5'd0);
            wait_done();
        end
        for (int i = 0; i < 6; i++) begin
            send(4'($urandom_range(6, 9)), $urandom, $urandom, SHW'($urandom_range(1, 31)));
            wait_done();
        end
        send(4'd8, 32'hffff_ffff, 32'd0, 5'd31);
        wait_done();

        // start held high through an lsl by 8: second request lands the cycle after done
        @(negedge clk);
        start = 1'b1; op = 4'd8; a = 32'h0000_00a5; b = 32'd0; shamt = 5'd8;
        expect_op(4'd8, 32'h0000_00a5, 32'd0, 5'd8, cyc + 1);
        expect_op(4'd0, 32'h1111_1111, 32'h2222_2222, 5'd0, cyc + 11);
        @(negedge clk);
        op = 4'd0; a = 32'h1111_1111; b = 32'h2222_2222; shamt = 5'd0;
        repeat (10) @(negedge clk);
        start = 1'b0;
        wait_done();

        // Reset in the 3rd EXEC cycle of a 10-step shift aborts it
        send(4'd9, 32'hf000_000f, 32'd0, 5'd10);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        held_res = '0;
        held_flg = '0;
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_result", 64'(result), 64'd0);
        check("abort_flags", 64'(flags), 64'd0);
        check("abort_alu_a", 64'(alu_a), 64'd0);
        check("abort_alu_b", 64'(alu_b), 64'd0);
        check("abort_alu_ctrl", 64'(alu_ctrl), 64'd0);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        send(4'd3, 32'h0f0f_0000, 32'h0000_f0f0, 5'd0);
        wait_done();

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
